fetch_queue: RTL and testbench

- Instruction-fetch front end that drives the PC register: produces pc_next and en, and consumes the current pc.
- Issues one instruction-memory request per accepted PC and buffers responses in a DEPTH-entry in-order queue.
- Presents {pc, instr} pairs to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 132 +++++++++++++
 tb/tb_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP_DEF = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{pc: 32'h0000_0000, instr: 32'h0000_0000, filled: 1'b0};

    function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc,
                                                   input logic [XLEN-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Fetch front end: issues one imem request per accepted PC, buffers responses
// in order and hands {pc, instr} to decode; redirects flush and drop in-flight data.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH   = 2,
    parameter logic [XLEN-1:0] PC_STEP = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            pc_en_o,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            out_valid_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_instr_o,
    input  logic            out_ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(1'b0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

    entry_t        entries_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] alloc_ptr_r;
    logic [PW-1:0] fill_ptr_r;
    logic [CW-1:0] alloc_cnt_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_cnt_r;

    entry_t head_entry_s;
    logic   req_valid_s;
    logic   accept_s;
    logic   rsp_fill_s;
    logic   out_valid_s;
    logic   pop_s;

    assign imem_req_addr_o = pc_i;

    // Handshake decode; counts are registered so a same-cycle pop never frees a slot early.
    always_comb begin
        head_entry_s = entries_r[head_r];
        req_valid_s  = !rst && !redirect_valid_i && (alloc_cnt_r < DEPTH_C) && (outstanding_r < DEPTH_C);
        accept_s     = req_valid_s && imem_req_ready_i;
        rsp_fill_s   = !rst && !redirect_valid_i && imem_rsp_valid_i && (drop_cnt_r == CNT_ZERO);
        out_valid_s  = !rst && !redirect_valid_i && head_entry_s.filled;
        pop_s        = out_valid_s && out_ready_i;
    end

    // PC register control and decode-side outputs; redirect outranks a normal advance.
    always_comb begin
        imem_req_valid_o = req_valid_s;
        out_valid_o      = out_valid_s;
        if (rst) begin
            pc_en_o     = 1'b0;
            pc_next_o   = pc_i;
            out_pc_o    = 32'h0000_0000;
            out_instr_o = 32'h0000_0000;
        end else begin
            out_pc_o    = head_entry_s.pc;
            out_instr_o = head_entry_s.instr;
            if (redirect_valid_i) begin
                pc_en_o   = 1'b1;
                pc_next_o = redirect_pc_i;
            end else if (accept_s) begin
                pc_en_o   = 1'b1;
                pc_next_o = pc_advance(pc_i, PC_STEP);
            end else begin
                pc_en_o   = 1'b0;
                pc_next_o = pc_i;
            end
        end
    end

    // Queue state: allocate on accept, fill on kept response, retire on pop, flush on redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= ENTRY_RESET;
            end
            head_r        <= PTR_ZERO;
            alloc_ptr_r   <= PTR_ZERO;
            fill_ptr_r    <= PTR_ZERO;
            alloc_cnt_r   <= CNT_ZERO;
            outstanding_r <= CNT_ZERO;
            drop_cnt_r    <= CNT_ZERO;
        end else if (redirect_valid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= ENTRY_RESET;
            end
            head_r        <= PTR_ZERO;
            alloc_ptr_r   <= PTR_ZERO;
            fill_ptr_r    <= PTR_ZERO;
            alloc_cnt_r   <= CNT_ZERO;
            outstanding_r <= outstanding_r - CW'(imem_rsp_valid_i);
            drop_cnt_r    <= outstanding_r - CW'(imem_rsp_valid_i);
        end else begin
            if (accept_s) begin
                entries_r[alloc_ptr_r].pc     <= pc_i;
                entries_r[alloc_ptr_r].filled <= 1'b0;
                alloc_ptr_r                   <= alloc_ptr_r + PTR_ONE;
            end
            if (rsp_fill_s) begin
                entries_r[fill_ptr_r].instr  <= imem_rsp_data_i;
                entries_r[fill_ptr_r].filled <= 1'b1;
                fill_ptr_r                   <= fill_ptr_r + PTR_ONE;
            end
            if (imem_rsp_valid_i && (drop_cnt_r != CNT_ZERO)) begin
                drop_cnt_r <= drop_cnt_r - CNT_ONE;
            end
            if (pop_s) begin
                entries_r[head_r].filled <= 1'b0;
                head_r                   <= head_r + PTR_ONE;
            end
            outstanding_r <= outstanding_r + CW'(accept_s) - CW'(imem_rsp_valid_i);
            alloc_cnt_r   <= alloc_cnt_r + CW'(accept_s) - CW'(pop_s);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a behavioural PC register and imem drive the DUT,
// expected output PCs are queued per scenario and a monitor pops and compares them.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic [31:0] pc_next_o;
    logic        pc_en_o;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_instr_o;
    logic        out_ready_i;

    fetch_queue #(.DEPTH(2), .PC_STEP(32'd4)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .pc_next_o        (pc_next_o),
        .pc_en_o          (pc_en_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .out_valid_o      (out_valid_o),
        .out_pc_o         (out_pc_o),
        .out_instr_o      (out_instr_o),
        .out_ready_i      (out_ready_i)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          lat   = 1;
    int          cyc   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mq_addr [$];
    int          mq_due [$];

    logic        s_rst, s_acc, s_en, s_req, s_ov, s_rsp;
    logic [31:0] s_next, s_addr, s_opc, s_oin, s_pc;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, then after posedge advance the PC register and memory.
    task automatic cycle();
        @(negedge clk);
        s_rst  = rst;
        s_acc  = imem_req_valid_o && imem_req_ready_i;
        s_en   = pc_en_o;
        s_next = pc_next_o;
        s_req  = imem_req_valid_o;
        s_addr = imem_req_addr_o;
        s_ov   = out_valid_o;
        s_opc  = out_pc_o;
        s_oin  = out_instr_o;
        s_pc   = pc_i;
        s_rsp  = imem_rsp_valid_i;
        if (s_req) chk("req_addr", s_addr, s_pc);
        @(posedge clk);
        #1;
        if (s_acc) begin
            mq_addr.push_back(s_addr);
            mq_due.push_back(cyc + lat);
        end
        cyc++;
        if (s_en) pc_i = s_next;
        if (s_rst) begin
            mq_addr.delete();
            mq_due.delete();
        end
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_fn(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = 32'h0000_0000;
        end
    endtask

    // Two reset cycles (memory is reset too); the first checks the gated outputs.
    task automatic do_reset();
        rst              = 1'b1;
        redirect_valid_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0000_0000;
        mq_addr.delete();
        mq_due.delete();
        cycle();
        chk("rst_pc_en", 32'(s_en), 32'd0);
        chk("rst_req_valid", 32'(s_req), 32'd0);
        chk("rst_out_valid", 32'(s_ov), 32'd0);
        chk("rst_pc_next", s_next, s_pc);
        chk("rst_out_pc", s_opc, 32'h0000_0000);
        chk("rst_out_instr", s_oin, 32'h0000_0000);
        cycle();
        rst  = 1'b0;
        pc_i = 32'h0000_0000;
    endtask

    task automatic drain(input string name, input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) cycle();
        out_ready_i = 1'b0;
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Scoreboard monitor: every decode handshake must match the head of the expected queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL out_unexpected: got pc 0x%08h, want no output", out_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc_o, e);
                    chk("out_instr", out_instr_o, mem_fn(e));
                end
            end
        end
    end

    initial begin
        int first;
        int acc_n;
        rst              = 1'b1;
        pc_i             = 32'h0000_1234;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0000_0000;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0000_0000;
        out_ready_i      = 1'b0;
        do_reset();

        // Streaming from PC 0 with a 1-cycle memory.
        lat = 1;
        out_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(k * 4));
        first = -1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            cycle();
            if (s_ov && first < 0) first = c;
        end
        chk("stream_first_out_cycle", 32'(first), 32'd2);
        drain("stream", 0);

        // Decode backpressure: only DEPTH requests go out, then the PC holds.
        do_reset();
        acc_n = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            acc_n += int'(s_acc);
        end
        chk("bp_accepts", 32'(acc_n), 32'd2);
        chk("bp_req_valid", 32'(s_req), 32'd0);
        chk("bp_pc_en", 32'(s_en), 32'd0);
        chk("bp_out_valid", 32'(s_ov), 32'd1);
        chk("bp_pc", pc_i, 32'h0000_0008);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        exp_q.push_back(32'h0000_0008);
        exp_q.push_back(32'h0000_000C);
        out_ready_i = 1'b1;
        drain("backpressure", 30);

        // Redirect with two requests in flight on a 4-cycle memory.
        do_reset();
        lat = 4;
        out_ready_i = 1'b1;
        cycle();
        chk("rd_acc0", 32'(s_acc), 32'd1);
        cycle();
        chk("rd_acc1", 32'(s_acc), 32'd1);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0100;
        cycle();
        chk("rd_pc_en", 32'(s_en), 32'd1);
        chk("rd_pc_next", s_next, 32'h0000_0100);
        chk("rd_req_valid", 32'(s_req), 32'd0);
        redirect_valid_i = 1'b0;
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0104);
        exp_q.push_back(32'h0000_0108);
        drain("redirect", 60);

        // Redirect in the same cycle as a response and a would-be decode handshake.
        do_reset();
        lat = 1;
        out_ready_i = 1'b1;
        cycle();
        cycle();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0200;
        cycle();
        chk("rc_rsp_seen", 32'(s_rsp), 32'd1);
        chk("rc_out_valid", 32'(s_ov), 32'd0);
        chk("rc_pc_next", s_next, 32'h0000_0200);
        redirect_valid_i = 1'b0;
        exp_q.push_back(32'h0000_0200);
        exp_q.push_back(32'h0000_0204);
        exp_q.push_back(32'h0000_0208);
        drain("redirect_coinc", 40);

        // Memory stall for five cycles with the address parked at 0x8.
        do_reset();
        out_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(32'(k * 4));
        cycle();
        cycle();
        imem_req_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("stall_pc_en", 32'(s_en), 32'd0);
            chk("stall_pc", s_pc, 32'h0000_0008);
        end
        chk("stall_req_valid", 32'(s_req), 32'd1);
        imem_req_ready_i = 1'b1;
        cycle();
        chk("stall_release_acc", 32'(s_acc), 32'd1);
        chk("stall_release_next", s_next, 32'h0000_000C);
        drain("stall", 40);

        // Reset with the queue full and one response still outstanding.
        do_reset();
        lat = 2;
        out_ready_i = 1'b0;
        cycle();
        cycle();
        cycle();
        chk("mr_full_req_valid", 32'(s_req), 32'd0);
        do_reset();
        cycle();
        chk("mr_out_valid", 32'(s_ov), 32'd0);
        chk("mr_req_valid", 32'(s_req), 32'd1);
        chk("mr_out_pc", s_opc, 32'h0000_0000);
        chk("mr_out_instr", s_oin, 32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        out_ready_i = 1'b1;
        drain("post_reset", 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
